// File: rtl/fetch_pkg.sv
// Shared fetch/execute definitions: opcodes, special words, FSM encoding, instruction layout.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH  = 128;
  localparam int unsigned FETCH_ADDR_W = 8;
  localparam int unsigned WORD_W       = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NAND = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_SWAP = 4'b0011;
  localparam logic [3:0] OP_NOP  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JC   = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [WORD_W-1:0] NOP_WORD = 8'h40;
  localparam logic [WORD_W-1:0] HLT_WORD = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] data;
  } instr_t;

endpackage

// File: rtl/fetch_prog_mem.sv
// Single-port program RAM; the registered read port doubles as the instruction register.
module fetch_prog_mem
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_DEPTH,
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  instr_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              squash,
  output instr_t            rd_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  instr_t            rd_data_d;
  instr_t            rd_data_q;
  logic              wr_in_range_c;
  logic              rd_in_range_c;

  assign wr_in_range_c = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
  assign rd_in_range_c = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);

  // Array is deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_c) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (squash) begin
      rd_data_d = instr_t'(NOP_WORD);
    end else if (rd_en) begin
      rd_data_d = rd_in_range_c ? instr_t'(mem[rd_addr[IDX_W-1:0]]) : instr_t'(HLT_WORD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= instr_t'(NOP_WORD);
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: program load, PC sequencing, halt detection.
// Define FETCH_BRANCH_EN to resolve jmp/jc/jz; otherwise they flow through as plain words.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_DEPTH,
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              run,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [7:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;
  logic              load_ready_q, load_ready_d;
  logic              wr_en_c;
  logic              rd_en_c;
  logic              squash_c;
  logic              taken_c;
  instr_t            instr_c;

  fetch_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (load_addr),
    .wr_data (instr_t'(load_data)),
    .rd_en   (rd_en_c),
    .rd_addr (pc_q),
    .squash  (squash_c),
    .rd_data (instr_c)
  );

`ifdef FETCH_BRANCH_EN
  // Branch condition evaluated against flags present while the branch sits in the IR.
  always_comb begin
    taken_c = 1'b0;
    if (instr_valid_q) begin
      case (instr_c.opcode)
        OP_JMP:  taken_c = 1'b1;
        OP_JC:   taken_c = flag_c;
        OP_JZ:   taken_c = flag_z;
        default: taken_c = 1'b0;
      endcase
    end
  end
`else
  logic unused_flags_c;
  assign unused_flags_c = flag_c ^ flag_z;
  assign taken_c        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    wr_en_c       = 1'b0;
    rd_en_c       = 1'b0;
    squash_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          wr_en_c = 1'b1;
        end else if (run) begin
          state_d       = ST_RUN;
          pc_d          = '0;
          instr_valid_d = 1'b0;
          squash_c      = 1'b1;
        end
      end
      ST_RUN: begin
        // pc already points one past the word in the IR, so a taken target is pc + offset.
        if (instr_valid_q && instr_c.opcode == OP_HLT) begin
          state_d       = ST_HALT;
          instr_valid_d = 1'b0;
        end else if (taken_c) begin
          pc_d          = pc_q + ADDR_W'(instr_c.data);
          instr_valid_d = 1'b0;
          squash_c      = 1'b1;
        end else begin
          rd_en_c       = 1'b1;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
        end
      end
      ST_HALT: begin
        if (run) begin
          state_d       = ST_RUN;
          pc_d          = '0;
          instr_valid_d = 1'b0;
          squash_c      = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        pc_d          = '0;
        instr_valid_d = 1'b0;
      end
    endcase
    halted_d     = (state_d == ST_HALT);
    load_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      load_ready_q  <= load_ready_d;
    end
  end

  assign instruction = instr_c;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign load_ready  = load_ready_q;

endmodule
